// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - opcode constants, FSM states and opcode decode for the data memory controller.
package dmem_pkg;

  localparam int LANE_N = 4;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  typedef struct packed {
    logic  legal;
    logic  store;
    logic  sext;
    size_e size;
  } op_dec_t;

  function automatic op_dec_t decode_op(input logic [5:0] op);
    op_dec_t d;
    d.legal = 1'b1;
    d.store = 1'b0;
    d.sext  = 1'b0;
    d.size  = SZ_WORD;
    case (op)
      OP_LB:   begin d.sext = 1'b1; d.size = SZ_BYTE; end
      OP_LBU:  d.size = SZ_BYTE;
      OP_LH:   begin d.sext = 1'b1; d.size = SZ_HALF; end
      OP_LHU:  d.size = SZ_HALF;
      OP_LW:   d.size = SZ_WORD;
      OP_SB:   begin d.store = 1'b1; d.size = SZ_BYTE; end
      OP_SH:   begin d.store = 1'b1; d.size = SZ_HALF; end
      OP_SW:   begin d.store = 1'b1; d.size = SZ_WORD; end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dmem_bank_ram.sv
// rtl/dmem_bank_ram.sv - single-port 32-bit word RAM with per-lane write enables and registered read.
module dmem_bank_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH_W = 14
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [LANE_N-1:0] be,
  input  logic [DEPTH_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [2**DEPTH_W];
  logic [31:0] rdata_q;

  // Read register only updates on a read, so it holds across a stalled response.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < LANE_N; i++) begin
          if (be[i]) mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - MIPS load/store data memory controller with clear-on-reset sweep.
// Define DMEM_ALIGN_CHK_EN to report misaligned halfword/word accesses instead of force-aligning them.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int FWD_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              fwd_sel,
  input  logic [31:0]       fwd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int WA = ADDR_W - 2;

  state_e          state_q, state_d;
  logic [WA-1:0]   cnt_q, cnt_d;
  logic            init_done_q, init_done_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic            rsp_load_q, rsp_load_d;
  logic            rsp_sext_q, rsp_sext_d;
  size_e           rsp_size_q, rsp_size_d;
  logic [1:0]      rsp_off_q, rsp_off_d;

  op_dec_t           dec;
  logic [1:0]        off;
  logic              misalign;
  logic              err;
  logic              accept;
  logic [31:0]       st_data;
  logic [31:0]       lane_data;
  logic [LANE_N-1:0] lane_be;

  logic              ram_en;
  logic              ram_we;
  logic [LANE_N-1:0] ram_be;
  logic [WA-1:0]     ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  logic [31:0]       shifted;
  logic [31:0]       ext;

  assign req_ready = (state_q == RUN) && (!rsp_valid_q || rsp_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    dec      = decode_op(req_op);
    off      = req_addr[1:0];
    misalign = 1'b0;
`ifdef DMEM_ALIGN_CHK_EN
    misalign = ((dec.size == SZ_HALF) && off[0]) || ((dec.size == SZ_WORD) && (off != 2'b00));
`else
    if (dec.size == SZ_HALF) off[0] = 1'b0;
    else if (dec.size == SZ_WORD) off = 2'b00;
`endif
    err     = !dec.legal || misalign;
    st_data = ((FWD_EN != 0) && fwd_sel) ? fwd_data : req_wdata;
    case (dec.size)
      SZ_BYTE: begin lane_be = 4'b0001 << off; lane_data = {4{st_data[7:0]}}; end
      SZ_HALF: begin lane_be = 4'b0011 << off; lane_data = {2{st_data[15:0]}}; end
      default: begin lane_be = 4'b1111;        lane_data = st_data;            end
    endcase
  end

  // During INIT the sweep owns the RAM port; afterwards only error-free accepted requests touch it.
  always_comb begin
    if (state_q == INIT) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_be    = '1;
      ram_addr  = cnt_q;
      ram_wdata = '0;
    end else begin
      ram_en    = accept && !err;
      ram_we    = dec.store;
      ram_be    = lane_be;
      ram_addr  = req_addr[ADDR_W-1:2];
      ram_wdata = lane_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_load_d  = rsp_load_q;
    rsp_sext_d  = rsp_sext_q;
    rsp_size_d  = rsp_size_q;
    rsp_off_d   = rsp_off_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d     = RUN;
          init_done_d = 1'b1;
          cnt_d       = '0;
        end
      end
      default: ;
    endcase
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = err;
      rsp_load_d  = !dec.store && !err;
      rsp_sext_d  = dec.sext;
      rsp_size_d  = dec.size;
      rsp_off_d   = off;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_load_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_load_q  <= 1'b0;
      rsp_sext_q  <= 1'b0;
      rsp_size_q  <= SZ_WORD;
      rsp_off_q   <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_load_q  <= rsp_load_d;
      rsp_sext_q  <= rsp_sext_d;
      rsp_size_q  <= rsp_size_d;
      rsp_off_q   <= rsp_off_d;
    end
  end

  dmem_bank_ram #(
    .DEPTH_W (WA)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Lane extraction works off registered request fields and the held RAM read register.
  always_comb begin
    shifted = ram_rdata >> {rsp_off_q, 3'b000};
    case (rsp_size_q)
      SZ_BYTE: ext = rsp_sext_q ? {{24{shifted[7]}}, shifted[7:0]}   : {24'b0, shifted[7:0]};
      SZ_HALF: ext = rsp_sext_q ? {{16{shifted[15]}}, shifted[15:0]} : {16'b0, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_load_q ? ext : 32'h0;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed self-checking bench for data_mem_ctrl.
module tb_data_mem_ctrl;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_op;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        fwd_sel;
  logic [31:0] fwd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_W(16), .FWD_EN(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .fwd_sel   (fwd_sel),
    .fwd_data  (fwd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_done (init_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic wait_init(input string tag);
    int n;
    logic rdy_seen;
    n = 0;
    rdy_seen = 1'b0;
    while (n < 20000) begin
      @(posedge clk);
      #1;
      n++;
      if (init_done) break;
      if (req_ready) rdy_seen = 1'b1;
    end
    check({tag, "_init_cycles"}, 32'(n), 32'd16384);
    check({tag, "_ready_in_init"}, 32'(rdy_seen), 32'd0);
  endtask

  task automatic issue(input logic [5:0] op, input logic [15:0] a, input logic [31:0] wd,
                       input logic fs, input logic [31:0] fd,
                       output logic [31:0] rd, output logic er);
    int n;
    @(negedge clk);
    req_op = op; req_addr = a; req_wdata = wd; fwd_sel = fs; fwd_data = fd; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("issue_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0; fwd_sel = 1'b0;
    @(negedge clk);
    check("issue_rsp_valid", 32'(rsp_valid), 32'd1);
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  logic [5:0]  t_op   [11];
  logic [15:0] t_addr [11];
  logic [31:0] t_exp  [11];

  initial begin
    logic [31:0] rd;
    logic        er;

    t_op[0]  = OP_LB;  t_addr[0]  = 16'h0020; t_exp[0]  = 32'h00000001;
    t_op[1]  = OP_LBU; t_addr[1]  = 16'h0020; t_exp[1]  = 32'h00000001;
    t_op[2]  = OP_LH;  t_addr[2]  = 16'h0020; t_exp[2]  = 32'h00007F01;
    t_op[3]  = OP_LHU; t_addr[3]  = 16'h0020; t_exp[3]  = 32'h00007F01;
    t_op[4]  = OP_LW;  t_addr[4]  = 16'h0020; t_exp[4]  = 32'h80FF7F01;
    t_op[5]  = OP_LB;  t_addr[5]  = 16'h0023; t_exp[5]  = 32'hFFFFFF80;
    t_op[6]  = OP_LBU; t_addr[6]  = 16'h0023; t_exp[6]  = 32'h00000080;
    t_op[7]  = OP_LH;  t_addr[7]  = 16'h0022; t_exp[7]  = 32'hFFFF80FF;
    t_op[8]  = OP_LHU; t_addr[8]  = 16'h0022; t_exp[8]  = 32'h000080FF;
    t_op[9]  = OP_LB;  t_addr[9]  = 16'h0021; t_exp[9]  = 32'h0000007F;
    t_op[10] = OP_LB;  t_addr[10] = 16'h0022; t_exp[10] = 32'hFFFFFFFF;

    rst_n = 1'b0; req_valid = 1'b0; req_op = 6'h0; req_addr = 16'h0;
    req_wdata = 32'h0; fwd_sel = 1'b0; fwd_data = 32'h0; rsp_ready = 1'b1;
    #12;
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);

    // Reset pulse in the middle of the clear sweep.
    @(negedge clk) rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("midinit_init_done", 32'(init_done), 32'd0);
    check("midinit_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("midinit_rst_init_done", 32'(init_done), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    wait_init("first");

    issue(OP_LW, 16'h0010, 32'h0, 1'b0, 32'h0, rd, er);
    check("lw_cleared", rd, 32'h0);
    check("lw_cleared_err", 32'(er), 32'd0);

    issue(OP_SW, 16'h0020, 32'h80FF7F01, 1'b0, 32'h0, rd, er);
    check("sw_rdata", rd, 32'h0);
    check("sw_err", 32'(er), 32'd0);
    for (int i = 0; i < 11; i++) begin
      issue(t_op[i], t_addr[i], 32'h0, 1'b0, 32'h0, rd, er);
      check($sformatf("load_%0d", i), rd, t_exp[i]);
    end

    issue(OP_SW, 16'h0020, 32'h11223344, 1'b0, 32'h0, rd, er);
    issue(OP_SB, 16'h0021, 32'h000000AA, 1'b0, 32'h0, rd, er);
    issue(OP_LW, 16'h0020, 32'h0, 1'b0, 32'h0, rd, er);
    check("sb_lane1", rd, 32'h1122AA44);
    issue(OP_SH, 16'h0022, 32'h12345678, 1'b1, 32'h0000BEEF, rd, er);
    issue(OP_LW, 16'h0020, 32'h0, 1'b0, 32'h0, rd, er);
    check("sh_fwd", rd, 32'hBEEFAA44);

    // Store immediately followed by a load of the same word.
    @(negedge clk);
    req_op = OP_SW; req_addr = 16'h0040; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
    check("b2b_ready0", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_op = OP_LW;
    @(negedge clk);
    check("b2b_st_valid", 32'(rsp_valid), 32'd1);
    check("b2b_st_rdata", rsp_rdata, 32'h0);
    check("b2b_ready1", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("b2b_ld_valid", 32'(rsp_valid), 32'd1);
    check("b2b_ld_rdata", rsp_rdata, 32'hCAFEF00D);
    @(negedge clk);

    // Backpressure: response held for three cycles while the next request waits.
    req_op = OP_LW; req_addr = 16'h0020; req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk);
    #1 req_op = OP_LBU;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("stall_valid_%0d", k), 32'(rsp_valid), 32'd1);
      check($sformatf("stall_rdata_%0d", k), rsp_rdata, 32'hBEEFAA44);
      check($sformatf("stall_err_%0d", k), 32'(rsp_err), 32'd0);
      check($sformatf("stall_ready_%0d", k), 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #1 check("release_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("release_valid", 32'(rsp_valid), 32'd1);
    check("release_rdata", rsp_rdata, 32'h00000044);
    @(negedge clk);
    check("drained_valid", 32'(rsp_valid), 32'd0);

    issue(6'b000000, 16'h0020, 32'hFFFFFFFF, 1'b0, 32'h0, rd, er);
    check("illegal_rdata", rd, 32'h0);
    check("illegal_err", 32'(er), 32'd1);
    issue(OP_LW, 16'h0020, 32'h0, 1'b0, 32'h0, rd, er);
    check("illegal_nowrite", rd, 32'hBEEFAA44);

    issue(OP_LW, 16'h0022, 32'h0, 1'b0, 32'h0, rd, er);
`ifdef DMEM_ALIGN_CHK_EN
    check("misalign_rdata", rd, 32'h0);
    check("misalign_err", 32'(er), 32'd1);
`else
    check("misalign_rdata", rd, 32'hBEEFAA44);
    check("misalign_err", 32'(er), 32'd0);
`endif

    // Reset while a response is pending, then confirm memory is cleared again.
    @(negedge clk);
    req_op = OP_LW; req_addr = 16'h0020; req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("pend_valid", 32'(rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("pend_rst_valid", 32'(rsp_valid), 32'd0);
    check("pend_rst_rdata", rsp_rdata, 32'h0);
    check("pend_rst_err", 32'(rsp_err), 32'd0);
    check("pend_rst_init_done", 32'(init_done), 32'd0);
    check("pend_rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; rsp_ready = 1'b1;
    wait_init("second");
    issue(OP_LW, 16'h0020, 32'h0, 1'b0, 32'h0, rd, er);
    check("recleared_20", rd, 32'h0);
    issue(OP_LW, 16'h0040, 32'h0, 1'b0, 32'h0, rd, er);
    check("recleared_40", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
